// File: rtl/servisia_gpio_pkg.sv
// rtl/servisia_gpio_pkg.sv - register offsets and width limits for servisia_gpio
package servisia_gpio_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic [2:0] OFF_OUT      = 3'd0;
    localparam logic [2:0] OFF_DIR      = 3'd1;
    localparam logic [2:0] OFF_IN       = 3'd2;
    localparam logic [2:0] OFF_SET      = 3'd3;
    localparam logic [2:0] OFF_CLR      = 3'd4;
    localparam logic [2:0] OFF_TGL      = 3'd5;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd6;
    localparam logic [2:0] OFF_IRQ_PEND = 3'd7;

endpackage

// File: rtl/servisia_gpio_if.sv
// rtl/servisia_gpio_if.sv - register bus bundle for servisia_gpio
interface servisia_gpio_if;

    logic [2:0]  adr;
    logic [31:0] dat;
    logic        we;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, we, stb, input rdt, ack);
    modport slave  (input adr, dat, we, stb, output rdt, ack);

endinterface

// File: rtl/servisia_sync.sv
// rtl/servisia_sync.sv - WIDTH x STAGES resettable input synchroniser
module servisia_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/servisia_gpio.sv
// rtl/servisia_gpio.sv - memory-mapped GPIO block; edge interrupts enabled by SERVISIA_GPIO_IRQ_EN
module servisia_gpio
    import servisia_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_rdt_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    logic [WIDTH-1:0]     out_q, out_d, dir_q, dir_d, in_sync, wdat;
    logic [WIDTH-1:0]     irq_en_v, irq_pend_v;
    logic [MAX_WIDTH-1:0] rd_val, rdt_q, rdt_d;
    logic                 ack_q, hold_q, acc, wr;
    logic                 unused_dat;

    assign wdat       = wb_dat_i[WIDTH-1:0];
    assign unused_dat = ^wb_dat_i;

    // hold_q blocks a strobe left high across reset until the master drops it.
    assign acc = wb_stb_i & ~ack_q & ~hold_q;
    assign wr  = acc & wb_we_i;

    servisia_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (gpio_i),
        .q_o   (in_sync)
    );

    always_comb begin
        rd_val = '0;
        case (wb_adr_i)
            OFF_OUT:      rd_val[WIDTH-1:0] = out_q;
            OFF_DIR:      rd_val[WIDTH-1:0] = dir_q;
            OFF_IN:       rd_val[WIDTH-1:0] = in_sync;
            OFF_IRQ_EN:   rd_val[WIDTH-1:0] = irq_en_v;
            OFF_IRQ_PEND: rd_val[WIDTH-1:0] = irq_pend_v;
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        rdt_d = acc ? rd_val : '0;
        if (wr) begin
            case (wb_adr_i)
                OFF_OUT: out_d = wdat;
                OFF_DIR: dir_d = wdat;
                OFF_SET: out_d = out_q | wdat;
                OFF_CLR: out_d = out_q & ~wdat;
                OFF_TGL: out_d = out_q ^ wdat;
                default: out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_q  <= '0;
            dir_q  <= '0;
            ack_q  <= 1'b0;
            rdt_q  <= '0;
            hold_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ack_q  <= acc;
            rdt_q  <= rdt_d;
            hold_q <= hold_q & wb_stb_i;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_rdt_o  = rdt_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;

`ifdef SERVISIA_GPIO_IRQ_EN
    localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] en_q, pend_q, pend_d, prev_q, rise, clr;
    logic [2:0]       prime_q;
    logic             armed, irq_q;

    // Edges are ignored until the synchroniser has flushed the reset zeros,
    // so pads already high during reset never raise a pending bit.
    assign armed  = (prime_q == PRIME_CYCLES);
    assign rise   = armed ? (in_sync & ~prev_q) : '0;
    assign clr    = (wr && wb_adr_i == OFF_IRQ_PEND) ? wdat : '0;
    assign pend_d = (pend_q & ~clr) | rise;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q    <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            prime_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            prev_q <= in_sync;
            pend_q <= pend_d;
            irq_q  <= |(pend_q & en_q);
            if (!armed) prime_q <= prime_q + 3'd1;
            if (wr && wb_adr_i == OFF_IRQ_EN) en_q <= wdat;
        end
    end

    assign irq_en_v   = en_q;
    assign irq_pend_v = pend_q;
    assign irq_o      = irq_q;
`else
    assign irq_en_v   = '0;
    assign irq_pend_v = '0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_servisia_gpio.sv
// tb/tb_servisia_gpio.sv - self-checking bench for servisia_gpio
module tb_servisia_gpio;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gpio_in, gpio_out, gpio_oe;
    logic         irq;

    servisia_gpio_if bus();

    servisia_gpio #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (bus.adr),
        .wb_dat_i  (bus.dat),
        .wb_we_i   (bus.we),
        .wb_stb_i  (bus.stb),
        .wb_rdt_o  (bus.rdt),
        .wb_ack_o  (bus.ack),
        .gpio_i    (gpio_in),
        .gpio_o    (gpio_out),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge, returns at a negedge one cycle after the ack cycle.
    task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] d, output logic [31:0] r);
        bus.we  = we;
        bus.adr = a;
        bus.dat = d;
        bus.stb = 1'b1;
        @(negedge clk);
        check("ack_cycle", {31'd0, bus.ack}, 32'd1);
        r       = bus.rdt;
        bus.stb = 1'b0;
        @(negedge clk);
        check("ack_pulse", {31'd0, bus.ack}, 32'd0);
        check("rdt_idle", bus.rdt, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        xfer(1'b1, a, d, r);
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, r);
        check(name, r, exp);
    endtask

    typedef struct {
        logic         we;
        logic [2:0]   adr;
        logic [31:0]  dat;
        logic [31:0]  exp_rd;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  r;
        logic [W-1:0] out_m, dir_m, pad;
        logic [2:0]   wr_off [5];
        int           op;
        logic [31:0]  d;

        wr_off = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};

        vecs[0]  = '{1'b1, 3'd0, 32'h0000_00A5, 32'h0, 8'hA5};
        vecs[1]  = '{1'b1, 3'd3, 32'h0000_000F, 32'h0, 8'hAF};
        vecs[2]  = '{1'b1, 3'd4, 32'h0000_0081, 32'h0, 8'h2E};
        vecs[3]  = '{1'b1, 3'd5, 32'h0000_00FF, 32'h0, 8'hD1};
        vecs[4]  = '{1'b0, 3'd3, 32'h0,         32'h0, 8'hD1};
        vecs[5]  = '{1'b0, 3'd0, 32'h0,         32'hD1, 8'hD1};
        vecs[6]  = '{1'b1, 3'd0, 32'hFFFF_FF3C, 32'h0, 8'h3C};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,         32'h3C, 8'h3C};
        vecs[8]  = '{1'b1, 3'd1, 32'hFFFF_FFF0, 32'h0, 8'h3C};
        vecs[9]  = '{1'b0, 3'd1, 32'h0,         32'hF0, 8'h3C};
        vecs[10] = '{1'b1, 3'd2, 32'h0000_00FF, 32'h0, 8'h3C};
        vecs[11] = '{1'b0, 3'd2, 32'h0,         32'h0, 8'h3C};
        vecs[12] = '{1'b0, 3'd5, 32'h0,         32'h0, 8'h3C};

        rst     = 1'b1;
        gpio_in = '0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        bus.adr = '0;
        bus.dat = '0;
        repeat (3) @(negedge clk);
        check("rst_gpio_o", {24'd0, gpio_out}, 32'd0);
        check("rst_gpio_oe", {24'd0, gpio_oe}, 32'd0);
        check("rst_ack", {31'd0, bus.ack}, 32'd0);
        check("rst_rdt", bus.rdt, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        rd_check("reset_out", 3'd0, 32'd0);
        rd_check("reset_dir", 3'd1, 32'd0);
        rd_check("reset_in", 3'd2, 32'd0);

        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, r);
            if (!vecs[i].we) check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio_o", i), {24'd0, gpio_out}, {24'd0, vecs[i].exp_out});
        end
        check("oe_after_table", {24'd0, gpio_oe}, 32'h0000_00F0);

        for (int k = 0; k <= S; k++) begin
            gpio_in = '0;
            repeat (S + 2) @(negedge clk);
            gpio_in = 8'h12;
            repeat (k) @(negedge clk);
            rd_check($sformatf("in_latency_%0d", k), 3'd2, (k >= S) ? 32'h12 : 32'h0);
        end
        gpio_in = '0;
        repeat (S + 2) @(negedge clk);

        bus.we = 1'b0; bus.adr = 3'd0; bus.stb = 1'b1;
        @(negedge clk); check("b2b_ack1", {31'd0, bus.ack}, 32'd1);
        @(negedge clk); check("b2b_gap",  {31'd0, bus.ack}, 32'd0);
        @(negedge clk); check("b2b_ack2", {31'd0, bus.ack}, 32'd1);
        bus.stb = 1'b0;
        @(negedge clk); check("b2b_end",  {31'd0, bus.ack}, 32'd0);

`ifdef SERVISIA_GPIO_IRQ_EN
        wr(3'd7, 32'hFF);
        wr(3'd6, 32'h02);
        rd_check("irq_en_rd", 3'd6, 32'h02);
        check("irq_idle", {31'd0, irq}, 32'd0);
        gpio_in = 8'h02;
        repeat (S + 3) @(negedge clk);
        gpio_in = 8'h00;
        repeat (3) @(negedge clk);
        rd_check("pend_after_pulse", 3'd7, 32'h02);
        check("irq_asserted", {31'd0, irq}, 32'd1);
        wr(3'd7, 32'h02);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_check("pend_cleared", 3'd7, 32'h00);
        gpio_in = 8'h02;
        repeat (S) @(negedge clk);
        wr(3'd7, 32'h02);
        rd_check("edge_wins", 3'd7, 32'h02);
        wr(3'd7, 32'h02);
        rd_check("clear_no_edge", 3'd7, 32'h00);
        gpio_in = 8'h00;
        wr(3'd6, 32'h00);
`else
        wr(3'd6, 32'hFF);
        rd_check("noirq_en_rd", 3'd6, 32'h0);
        gpio_in = 8'hFF;
        repeat (S + 3) @(negedge clk);
        gpio_in = 8'h00;
        repeat (3) @(negedge clk);
        rd_check("noirq_pend_rd", 3'd7, 32'h0);
        check("noirq_irq", {31'd0, irq}, 32'd0);
`endif

        out_m = 8'h3C;
        dir_m = 8'hF0;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 6);
            d  = $urandom;
            if (op < 5) begin
                wr(wr_off[op], d);
                case (op)
                    0: out_m = d[W-1:0];
                    1: dir_m = d[W-1:0];
                    2: out_m = out_m | d[W-1:0];
                    3: out_m = out_m & ~d[W-1:0];
                    default: out_m = out_m ^ d[W-1:0];
                endcase
            end else if (op == 5) begin
                pad     = d[W-1:0];
                gpio_in = pad;
                repeat (S + 1) @(negedge clk);
                rd_check("rand_in", 3'd2, {24'd0, pad});
            end else begin
                rd_check("rand_out_rd", 3'd0, {24'd0, out_m});
                rd_check("rand_dir_rd", 3'd1, {24'd0, dir_m});
            end
            check("rand_gpio_o", {24'd0, gpio_out}, {24'd0, out_m});
            check("rand_gpio_oe", {24'd0, gpio_oe}, {24'd0, dir_m});
        end

        wr(3'd0, 32'h0);
        gpio_in = 8'hF0;
        bus.we = 1'b1; bus.adr = 3'd0; bus.dat = 32'h55; bus.stb = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        check("abort_ack_in_rst", {31'd0, bus.ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_no_ack_%0d", k), {31'd0, bus.ack}, 32'd0);
        end
        bus.stb = 1'b0;
        @(negedge clk);
        check("abort_gpio_o", {24'd0, gpio_out}, 32'd0);
        rd_check("abort_out_rd", 3'd0, 32'd0);
        repeat (8) @(negedge clk);
        rd_check("post_rst_in", 3'd2, 32'hF0);
        rd_check("post_rst_pend", 3'd7, 32'h0);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servisia_gpio.md
SERVISIA_GPIO -- requirements
Module: servisia_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of GPIO channels, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have port wb_clk_i, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port wb_adr_i, input, 3: word offset, bits [4:2] of the core bus address.
REQ-006 SHALL have port wb_dat_i, input, 32: write data.
REQ-007 SHALL have ports wb_we_i and wb_stb_i, input, 1 each: write enable and strobe.
REQ-008 SHALL have port wb_rdt_o, output, 32: read data.
REQ-009 SHALL have port wb_ack_o, output, 1: acknowledge.
REQ-010 SHALL have port gpio_i, input, WIDTH: asynchronous pad inputs.
REQ-011 SHALL have port gpio_o, output, WIDTH: pad output values.
REQ-012 SHALL have port gpio_oe_o, output, WIDTH: pad output enables, 1 = drive.
REQ-013 SHALL have port irq_o, output, 1: level interrupt.

Function
REQ-014 Register map, word offsets: 0 OUT rw, 1 DIR rw, 2 IN ro, 3 SET wo, 4 CLR wo, 5 TGL wo, 6 IRQ_EN rw, 7 IRQ_PEND rw1c.
REQ-015 wb_ack_o SHALL be a one-cycle pulse, asserted the cycle after wb_stb_i is sampled high while wb_ack_o is low.
REQ-016 wb_stb_i high during an ack cycle SHALL NOT start a new access; back-to-back accesses take at least 2 cycles each.
REQ-017 Register write effects and wb_rdt_o SHALL be valid in the ack cycle; wb_rdt_o SHALL be 0 outside ack cycles.
REQ-018 Read-data bits [31:WIDTH] SHALL read 0; write-data bits [31:WIDTH] SHALL be ignored.
REQ-019 Write-only offsets 3..5 SHALL read 0.
REQ-020 SET SHALL perform OUT |= dat, CLR SHALL perform OUT &= ~dat, and TGL SHALL perform OUT ^= dat, each in a single cycle.
REQ-021 gpio_o SHALL equal OUT and gpio_oe_o SHALL equal DIR, both driven directly from flops.
REQ-022 IN SHALL equal gpio_i after SYNC_STAGES flops; latency from a pad change to a readable value SHALL be SYNC_STAGES cycles.
REQ-023 IN SHALL reflect pad state regardless of DIR.
REQ-024 A rising edge SHALL be defined as synced bit 1 with the previous synced bit 0; a rising edge SHALL set the corresponding IRQ_PEND bit.
REQ-025 An IRQ_PEND bit that sees an edge and a write-1 clear in the same cycle SHALL stay set (edge wins).
REQ-026 irq_o SHALL be the registered value of |(IRQ_PEND & IRQ_EN), with 1-cycle latency.
REQ-027 Writes to IN SHALL be acknowledged and SHALL have no effect.

Reset
REQ-028 On wb_rst_i, OUT, DIR, IRQ_EN, IRQ_PEND, all synchroniser and edge flops, wb_ack_o, wb_rdt_o and irq_o SHALL be 0.
REQ-029 Reset asserted mid-access SHALL abort the access; no ack and no register update SHALL follow after release.
REQ-030 The first edge detection after reset release SHALL NOT flag any bit whose pad was already 1 during reset.

Configuration
REQ-031 With macro SERVISIA_GPIO_IRQ_EN defined, REQ-024..REQ-026 SHALL be implemented.
REQ-032 Without SERVISIA_GPIO_IRQ_EN, offsets 6..7 SHALL read 0, writes to them SHALL be acknowledged and ignored, irq_o SHALL be tied 0, and no edge or pending flops SHALL exist.

Structure
REQ-033 Package servisia_gpio_pkg SHALL hold the register offset constants and the maximum WIDTH constant.
REQ-034 Sub-module servisia_sync SHALL implement the parametrised WIDTH x SYNC_STAGES reset-able synchroniser.

Verification
REQ-035 Reset, then read OUT, DIR and IN with gpio_i=0 -> all read 0, each ack is a 1-cycle pulse arriving 1 cycle after stb.
REQ-036 Write OUT=0xA5, SET 0x0F, CLR 0x81, TGL 0xFF -> gpio_o sequence is 0xA5, 0xAF, 0x2E, 0xD1.
REQ-037 With WIDTH=8, write OUT=0xFFFF_FF3C, then read -> reads 0x0000_003C.
REQ-038 Drive gpio_i 0x00->0x12 -> IN reads 0x12 from the 2nd cycle after the change, not before.
REQ-039 With IRQ enabled: IRQ_EN=0x02, pulse gpio_i[1] -> IRQ_PEND=0x02 and irq_o=1; write 0x02 to IRQ_PEND -> irq_o=0 next cycle; a clear written in the same cycle as a new edge -> bit stays 1.
REQ-040 Assert wb_rst_i during a pending stb -> no ack, OUT unchanged at 0; same bench without the macro -> offset 7 reads 0 and irq_o stays 0.
